// File: rtl/adder_nios2_debug_jtag_scan_master_if.sv
// Purpose: bundles the command/response handshake and the virtual-JTAG
// port of the debug scan master into one interface.
//
// Signals:
//   cmd_valid/cmd_ready/cmd_ir/cmd_data  command request into the scan engine
//   rsp_valid/rsp_ready/rsp_data         shifted-out word back to the host
//   tck/tdi/tdo                          virtual-JTAG serial pins
//   ir_in                                virtual IR currently applied
//   vs_uir/vs_cdr/vs_sdr/vs_udr          virtual state strobes
//   jtag_state_rti                       run-test-idle indicator
//
// Modports:
//   master  the host side that issues commands and emulates the debug slave
//   slave   the scan engine that executes commands
interface adder_nios2_debug_jtag_scan_master_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_data;
  logic                tck;
  logic                tdi;
  logic                tdo;
  logic [IR_WIDTH-1:0] ir_in;
  logic                vs_uir;
  logic                vs_cdr;
  logic                vs_sdr;
  logic                vs_udr;
  logic                jtag_state_rti;

  modport master (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready, tdo,
    input  cmd_ready, rsp_valid, rsp_data, tck, tdi, ir_in,
           vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready, tdo,
    output cmd_ready, rsp_valid, rsp_data, tck, tdi, ir_in,
           vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti
  );
endinterface

// File: rtl/adder_nios2_debug_jtag_scan_master.sv
// Purpose: host-side initiator for the CPU debug slave's virtual-JTAG port.
// Each accepted command becomes an optional IR update followed by a DR
// capture, DR_WIDTH shift periods, DR update and RTI_TCKS periods of
// run-test-idle; the word shifted out of tdo is then returned.
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset; abandons any scan in progress
//   bus    slave view of the scan-master interface (command, response and
//          virtual-JTAG pins)
//
// Parameters:
//   DR_WIDTH     DR scan length in bits
//   IR_WIDTH     virtual IR width
//   HALF_PERIOD  clk cycles per tck phase (>= 1)
//   RTI_TCKS     tck periods spent in run-test-idle (>= 1)
module adder_nios2_debug_jtag_scan_master #(
  parameter int DR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int HALF_PERIOD = 2,
  parameter int RTI_TCKS    = 2
) (
  input logic clk,
  input logic reset,
  adder_nios2_debug_jtag_scan_master_if.slave bus
);

  localparam int PERIOD = 2 * HALF_PERIOD;
  localparam int CNT_W  = $clog2(PERIOD);
  localparam int MAX_PER = (DR_WIDTH > RTI_TCKS) ? DR_WIDTH : RTI_TCKS;
  localparam int PER_W  = $clog2(MAX_PER + 1);

  localparam logic [CNT_W-1:0] RISE_AT  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] LAST_AT  = CNT_W'(PERIOD - 1);
  localparam logic [PER_W-1:0] SDR_LAST = PER_W'(DR_WIDTH - 1);
  localparam logic [PER_W-1:0] RTI_LAST = PER_W'(RTI_TCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic [DR_WIDTH-1:0] shift_q, shift_d;
  logic                tdo_q, tdo_d;
  logic                tck_q, tck_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                ir_loaded_q, ir_loaded_d;

  // State register and datapath registers; reset drops everything at once,
  // so an interrupted scan never yields a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      per_q       <= '0;
      shift_q     <= '0;
      tdo_q       <= 1'b0;
      tck_q       <= 1'b0;
      ir_q        <= '0;
      ir_loaded_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      shift_q     <= shift_d;
      tdo_q       <= tdo_d;
      tck_q       <= tck_d;
      ir_q        <= ir_d;
      ir_loaded_q <= ir_loaded_d;
    end
  end

  // Next-state logic. cnt_q walks through one tck period: tck rises when the
  // low phase ends (cnt_q == RISE_AT) and falls at the period boundary
  // (cnt_q == LAST_AT), which is also the only point where the state and
  // the shift register move, keeping strobes and tdi stable around the
  // rising tck edge. per_q counts periods inside SDR and RTI.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    per_d       = per_q;
    shift_d     = shift_q;
    tdo_d       = tdo_q;
    tck_d       = tck_q;
    ir_d        = ir_q;
    ir_loaded_d = ir_loaded_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          shift_d = bus.cmd_data;
          cnt_d   = '0;
          per_d   = '0;
          tck_d   = 1'b0;
          // The IR update is only needed when the slave does not already
          // hold the requested instruction.
          if (!ir_loaded_q || (bus.cmd_ir != ir_q)) begin
            state_d     = S_UIR;
            ir_d        = bus.cmd_ir;
            ir_loaded_d = 1'b1;
          end else begin
            state_d = S_CDR;
          end
        end
      end

      S_DONE: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        if (cnt_q == RISE_AT) begin
          tck_d = 1'b1;
          if (state_q == S_SDR) begin
            tdo_d = bus.tdo;
          end
        end
        if (cnt_q == LAST_AT) begin
          cnt_d = '0;
          tck_d = 1'b0;
          case (state_q)
            S_UIR: state_d = S_CDR;
            S_CDR: begin
              state_d = S_SDR;
              per_d   = '0;
            end
            S_SDR: begin
              // The first captured bit ends up in bit 0 after DR_WIDTH shifts.
              shift_d = {tdo_q, shift_q[DR_WIDTH-1:1]};
              if (per_q == SDR_LAST) begin
                state_d = S_UDR;
                per_d   = '0;
              end else begin
                per_d = per_q + 1'b1;
              end
            end
            S_UDR: begin
              state_d = S_RTI;
              per_d   = '0;
            end
            S_RTI: begin
              if (per_q == RTI_LAST) begin
                state_d = S_DONE;
              end else begin
                per_d = per_q + 1'b1;
              end
            end
            default: state_d = state_q;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign bus.cmd_ready      = (state_q == S_IDLE);
  assign bus.rsp_valid      = (state_q == S_DONE);
  assign bus.rsp_data       = (state_q == S_DONE) ? shift_q : '0;
  assign bus.tck            = tck_q;
  assign bus.tdi            = (state_q == S_SDR) ? shift_q[0] : 1'b0;
  assign bus.ir_in          = ir_q;
  assign bus.vs_uir         = (state_q == S_UIR);
  assign bus.vs_cdr         = (state_q == S_CDR);
  assign bus.vs_sdr         = (state_q == S_SDR);
  assign bus.vs_udr         = (state_q == S_UDR);
  assign bus.jtag_state_rti = (state_q == S_RTI);

endmodule
